// File: rtl/writeback_queue.sv
// Writeback queue: merges ALU and load results into one register-file write port
// through a 4-entry FIFO. Define WB_BYPASS_EN to write a lone source straight through an empty queue.
module writeback_queue (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [3:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [3:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    output logic [3:0]  rf_rd,
    output logic [31:0] rf_write_data,
    output logic        rf_reg_write,
    output logic [15:0] busy_mask,
    output logic [2:0]  count
);

    localparam int DEPTH = 4;

    logic [3:0]  rd_mem   [DEPTH];
    logic [31:0] data_mem [DEPTH];

    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0] count_q, count_d;

    logic       mem_enq, alu_enq, deq, bypass, head_valid;
    logic [1:0] alu_slot, scan_slot;

    // NOTE: every signal written in always_comb gets a default at the top so no path leaves it unassigned (no latches).
    always_comb begin
        mem_ready = !rst && (count_q <= 3'd3);
        alu_ready = !rst && ((count_q <= 3'd2) || ((count_q == 3'd3) && !mem_valid));
`ifdef WB_BYPASS_EN
        bypass = !rst && (count_q == 3'd0) && (alu_valid ^ mem_valid);
`else
        bypass = 1'b0;
`endif
        // A bypassed result is consumed by the write port, so it never occupies a slot.
        mem_enq  = mem_valid && mem_ready && !bypass;
        alu_enq  = alu_valid && alu_ready && !bypass;
        deq      = (count_q != 3'd0);
        alu_slot = wr_ptr_q + 2'(mem_enq);
        wr_ptr_d = wr_ptr_q + 2'(mem_enq) + 2'(alu_enq);
        rd_ptr_d = rd_ptr_q + 2'(deq);
        count_d  = count_q + 3'(mem_enq) + 3'(alu_enq) - 3'(deq);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: payload storage has no reset; count_q alone decides which slots are meaningful.
    always_ff @(posedge clk) begin
        if (mem_enq) begin
            rd_mem[wr_ptr_q]   <= mem_rd;
            data_mem[wr_ptr_q] <= mem_data;
        end
        if (alu_enq) begin
            rd_mem[alu_slot]   <= alu_rd;
            data_mem[alu_slot] <= alu_data;
        end
    end

    always_comb begin
        head_valid    = !rst && (count_q != 3'd0);
        rf_reg_write  = head_valid;
        rf_rd         = head_valid ? rd_mem[rd_ptr_q] : 4'd0;
        rf_write_data = head_valid ? data_mem[rd_ptr_q] : 32'd0;
`ifdef WB_BYPASS_EN
        if (bypass) begin
            rf_reg_write  = 1'b1;
            rf_rd         = alu_valid ? alu_rd : mem_rd;
            rf_write_data = alu_valid ? alu_data : mem_data;
        end
`endif
    end

    // The head is still counted as busy during the cycle it is being written.
    always_comb begin
        busy_mask = 16'd0;
        scan_slot = 2'd0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_slot = rd_ptr_q + 2'(k);
            if (!rst && (3'(k) < count_q))
                busy_mask[rd_mem[scan_slot]] = 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench for writeback_queue: stimulus pushes expected rf writes,
// a monitor pops and compares them whenever rf_reg_write is high.
module tb_writeback_queue;

    typedef struct packed {
        logic [3:0]  rd;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, mem_valid;
    logic [3:0]  alu_rd, mem_rd;
    logic [31:0] alu_data, mem_data;
    logic        alu_ready, mem_ready;
    logic [3:0]  rf_rd;
    logic [31:0] rf_write_data;
    logic        rf_reg_write;
    logic [15:0] busy_mask;
    logic [2:0]  count;

    wr_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    writeback_queue dut (
        .clk           (clk),
        .rst           (rst),
        .alu_valid     (alu_valid),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .alu_ready     (alu_ready),
        .mem_valid     (mem_valid),
        .mem_rd        (mem_rd),
        .mem_data      (mem_data),
        .mem_ready     (mem_ready),
        .rf_rd         (rf_rd),
        .rf_write_data (rf_write_data),
        .rf_reg_write  (rf_reg_write),
        .busy_mask     (busy_mask),
        .count         (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive(input logic mv, input logic [3:0] mrd, input logic [31:0] mdat,
                         input logic av, input logic [3:0] ard, input logic [31:0] adat);
        mem_valid = mv;  mem_rd = mrd;  mem_data = mdat;
        alu_valid = av;  alu_rd = ard;  alu_data = adat;
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    endtask

    task automatic expect_wr(input logic [3:0] rd, input logic [31:0] data);
        exp_q.push_back('{rd: rd, data: data});
    endtask

    initial begin : monitor
        wr_t e;
        forever begin
            @(negedge clk);
            if (rf_reg_write === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rf_unexpected: got write rd=%0d data=%0h, expected no write", rf_rd, rf_write_data);
                end else begin
                    e = exp_q.pop_front();
                    check("rf_rd", 32'(rf_rd), 32'(e.rd));
                    check("rf_write_data", rf_write_data, e.data);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin : stimulus
        rst = 1'b1;
        drive(1'b1, 4'd1, 32'h1, 1'b1, 4'd2, 32'h2);
        repeat (2) @(posedge clk);
        #1;
        mid();
        check("rst_alu_ready", 32'(alu_ready), 32'd0);
        check("rst_mem_ready", 32'(mem_ready), 32'd0);
        check("rst_rf_reg_write", 32'(rf_reg_write), 32'd0);
        check("rst_busy_mask", 32'(busy_mask), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        cyc(); rst = 1'b0; idle();
        mid();
        check("idle_rf_rd", 32'(rf_rd), 32'd0);
        check("idle_count", 32'(count), 32'd0);

        // Single ALU write: visible one cycle after acceptance, gone the cycle after.
        cyc(); drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd3, 32'h0000_002A); expect_wr(4'd3, 32'd42);
        mid();
        check("single_alu_ready", 32'(alu_ready), 32'd1);
        check("single_no_same_cycle_write", 32'(rf_reg_write), 32'd0);
        cyc(); idle();
        mid();
        check("single_rf_reg_write", 32'(rf_reg_write), 32'd1);
        check("single_busy_mask", 32'(busy_mask), 32'h0008);
        check("single_count", 32'(count), 32'd1);
        cyc();
        mid();
        check("single_after_write", 32'(rf_reg_write), 32'd0);
        check("single_after_rd", 32'(rf_rd), 32'd0);
        check("single_after_data", rf_write_data, 32'd0);
        check("single_after_busy", 32'(busy_mask), 32'd0);

        // Dual write to r5: load value first, ALU value last.
        cyc(); drive(1'b1, 4'd5, 32'd1, 1'b1, 4'd5, 32'd2);
        expect_wr(4'd5, 32'd1); expect_wr(4'd5, 32'd2);
        mid();
        check("dual_mem_ready", 32'(mem_ready), 32'd1);
        check("dual_alu_ready", 32'(alu_ready), 32'd1);
        cyc(); idle();
        mid();
        check("dual_count_2", 32'(count), 32'd2);
        check("dual_busy_mask", 32'(busy_mask), 32'h0020);
        cyc();
        mid();
        check("dual_count_1", 32'(count), 32'd1);
        cyc();
        mid();
        check("dual_count_0", 32'(count), 32'd0);

        // Continuous dual offers: one entry drains per cycle, so occupancy settles at 3
        // and the ALU source is throttled while the load source is offering.
        cyc(); drive(1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h21);
        expect_wr(4'd1, 32'h11); expect_wr(4'd2, 32'h21);
        mid();
        check("bp_c1_count", 32'(count), 32'd0);
        cyc(); drive(1'b1, 4'd3, 32'h13, 1'b1, 4'd4, 32'h24);
        expect_wr(4'd3, 32'h13); expect_wr(4'd4, 32'h24);
        mid();
        check("bp_c2_count", 32'(count), 32'd2);
        check("bp_c2_alu_ready", 32'(alu_ready), 32'd1);
        cyc(); drive(1'b1, 4'd6, 32'h16, 1'b1, 4'd7, 32'h27);
        expect_wr(4'd6, 32'h16);
        mid();
        check("bp_c3_count", 32'(count), 32'd3);
        check("bp_c3_mem_ready", 32'(mem_ready), 32'd1);
        check("bp_c3_alu_ready", 32'(alu_ready), 32'd0);
        cyc(); drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd7, 32'h27);
        expect_wr(4'd7, 32'h27);
        mid();
        check("bp_c4_alu_ready", 32'(alu_ready), 32'd1);
        check("bp_c4_count", 32'(count), 32'd3);
        check("bp_c4_busy_mask", 32'(busy_mask), 32'h0058);
        cyc(); idle();
        mid();
        check("bp_c5_count", 32'(count), 32'd3);
        repeat (3) cyc();
        mid();
        check("bp_drained", 32'(count), 32'd0);

        // Ten back-to-back ALU writes walk the pointers round the ring more than twice.
        for (int i = 0; i < 10; i++) begin
            cyc(); drive(1'b0, 4'd0, 32'd0, 1'b1, 4'(i), 32'(i * 3));
            expect_wr(4'(i), 32'(i * 3));
            mid();
            check("wrap_alu_ready", 32'(alu_ready), 32'd1);
        end
        cyc(); idle();
        mid();
        check("wrap_tail_count", 32'(count), 32'd1);
        cyc();
        mid();
        check("wrap_drained", 32'(count), 32'd0);

        // Reset with three entries queued: only the entry written before reset reaches the rf.
        cyc(); drive(1'b1, 4'd8, 32'h80, 1'b1, 4'd9, 32'h90);
        expect_wr(4'd8, 32'h80);
        mid();
        cyc(); drive(1'b1, 4'd10, 32'hA0, 1'b1, 4'd11, 32'hB0);
        mid();
        cyc(); rst = 1'b1; drive(1'b1, 4'd13, 32'hD0, 1'b1, 4'd12, 32'hC0);
        mid();
        check("rstmid_count_before", 32'(count), 32'd3);
        check("rstmid_alu_ready", 32'(alu_ready), 32'd0);
        check("rstmid_mem_ready", 32'(mem_ready), 32'd0);
        check("rstmid_rf_reg_write", 32'(rf_reg_write), 32'd0);
        check("rstmid_busy_mask", 32'(busy_mask), 32'd0);
        cyc(); rst = 1'b0; drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd12, 32'hC0);
        expect_wr(4'd12, 32'hC0);
        mid();
        check("rstmid_count_after", 32'(count), 32'd0);
        check("rstmid_busy_after", 32'(busy_mask), 32'd0);
        check("rstmid_no_write", 32'(rf_reg_write), 32'd0);
        check("rstmid_resume_ready", 32'(alu_ready), 32'd1);
        cyc(); idle();
        mid();
        check("rstmid_resume_write", 32'(rf_reg_write), 32'd1);
        check("rstmid_resume_count", 32'(count), 32'd1);
        cyc();
        mid();
        check("final_count", 32'(count), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
